// File: rtl/acc_fp_pkg.sv
// rtl/acc_fp_pkg.sv - shared widths, state encoding and default latency for the acc_fp sequencer
package acc_fp_pkg;

  localparam int OPS_W   = 16;
  localparam int EXP_W   = 4;
  localparam int MAN_W   = 16;
  localparam int ACC_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/acc_fp_lat_timer.sv
// rtl/acc_fp_lat_timer.sv - loadable down-counter timing the acc_fp result latency
module acc_fp_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done,
  output logic         zero
);

  logic [W-1:0] wcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (load) begin
      wcnt <= load_val;
    end else if (dec && (wcnt != '0)) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  // done marks the last wait cycle; zero marks the cycle the result is valid
  assign done = (wcnt == W'(1));
  assign zero = (wcnt == '0);

endmodule

// File: rtl/acc_fp_ctrl.sv
// rtl/acc_fp_ctrl.sv - issues one product per LAT cycles to acc_fp and returns the final sum
module acc_fp_ctrl
  import acc_fp_pkg::*;
#(
  parameter int LAT   = ACC_LAT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [OPS_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             in_sgn,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_man,
  output logic [OPS_W-1:0] acc_ops,
  output logic             acc_sgn,
  output logic [EXP_W-1:0] acc_exp,
  output logic [MAN_W-1:0] acc_man,
  input  logic [OPS_W-1:0] acc_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPS_W-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  localparam int TW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  state_t           state_q, state_d;
  logic [OPS_W-1:0] psum_q, psum_d;
  logic [OPS_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fresh_q, fresh_d;
  logic             hs;
  logic             tmr_load, tmr_dec, tmr_done, tmr_zero;

  acc_fp_lat_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(LAT - 1)),
    .dec      (tmr_dec),
    .done     (tmr_done),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      psum_q     <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      psum_q     <= psum_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      fresh_q    <= fresh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    psum_d     = psum_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    fresh_d    = fresh_q;
    hs         = 1'b0;
    in_ready   = 1'b0;
    acc_ops    = '0;
    acc_sgn    = 1'b0;
    acc_exp    = '0;
    acc_man    = '0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !clear) begin
          psum_d  = bias;
          cnt_d   = '0;
          fresh_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        in_ready = !clear;
        hs       = in_valid && in_ready;
        // a fresh result is consumed in the very cycle acc_fp makes it valid
        acc_ops  = fresh_q ? acc_result : psum_q;
        if (fresh_q) psum_d = acc_result;
        fresh_d = 1'b0;
        if (hs) begin
          acc_sgn  = in_sgn;
          acc_exp  = in_exp;
          acc_man  = in_man;
          tmr_load = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            state_d = DRAIN;
          end else if (LAT == 1) begin
            state_d = ISSUE;
            fresh_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        acc_ops = psum_q;
        tmr_dec = 1'b1;
        if (tmr_done || (LAT == 1)) begin
          state_d = ISSUE;
          fresh_d = 1'b1;
        end
      end
      DRAIN: begin
        acc_ops = psum_q;
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          out_data_d = acc_result;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) state_d = IDLE;
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_acc_fp_ctrl.sv
// tb/tb_acc_fp_ctrl.sv - scoreboard bench for acc_fp_ctrl with a two-stage integer-add stub datapath
module tb_acc_fp_ctrl;

  localparam int LAT   = 2;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, clear;
  logic [15:0]      bias;
  logic             in_valid, in_ready, in_last, in_sgn;
  logic [3:0]       in_exp;
  logic [15:0]      in_man;
  logic [15:0]      acc_ops;
  logic             acc_sgn;
  logic [3:0]       acc_exp;
  logic [15:0]      acc_man;
  logic [15:0]      acc_result;
  logic             out_valid, out_ready;
  logic [15:0]      out_data;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  logic [15:0] stage1, stage2;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] man_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] ops_exp_q[$];
  logic [15:0] obs_ops[$];
  logic [20:0] obs_se[$];
  int          obs_cyc[$];

  acc_fp_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_sgn     (in_sgn),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .acc_ops    (acc_ops),
    .acc_sgn    (acc_sgn),
    .acc_exp    (acc_exp),
    .acc_man    (acc_man),
    .acc_result (acc_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .cnt        (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= acc_ops + acc_man;
      stage2 <= stage1;
    end
  end
  assign acc_result = stage2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic drive_vector(input logic [15:0] b, input int gap_after, input int gap_len,
                              output bit ok);
    int n;
    int k;
    ok = 1'b1;
    n = man_q.size();
    obs_ops.delete();
    obs_se.delete();
    obs_cyc.delete();
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_after) begin
        in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_man   = man_q[i];
      in_last  = (i == n - 1);
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
        k++;
        @(negedge clk);
      end
      if (!in_ready) begin
        ok = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      obs_ops.push_back(acc_ops);
      obs_se.push_back({acc_sgn, acc_exp, acc_man});
      obs_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_man   = '0;
  endtask

  task automatic wait_out(output int lat, output logic [15:0] data, output bit ok);
    lat = 0;
    ok = 1'b0;
    data = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        data = out_data;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000", {busy, out_valid, in_ready});
    end
    n_cmp++;
    if ({out_data, acc_ops, acc_man} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {out_data, acc_ops, acc_man});
    end
    n_cmp++;
    if (cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    bit ok;
    int lat;
    logic [15:0] d, e;
    man_q = '{16'd3};
    in_sgn = 1'b1;
    in_exp = 4'hA;
    exp_q.push_back(16'd8);
    ops_exp_q.push_back(16'd5);
    drive_vector(16'd5, -1, 0, ok);
    in_sgn = 1'b0;
    in_exp = '0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_handshake: got timeout expected handshake");
      return;
    end
    e = ops_exp_q.pop_front();
    n_cmp++;
    if (obs_ops[0] !== e) begin
      n_err++;
      $display("FAIL single_ops: got %0d expected %0d", obs_ops[0], e);
    end
    n_cmp++;
    if (obs_se[0] !== {1'b1, 4'hA, 16'd3}) begin
      n_err++;
      $display("FAIL single_mul_fields: got %h expected %h", obs_se[0], {1'b1, 4'hA, 16'd3});
    end
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== LAT + 1) begin
      n_err++;
      $display("FAIL single_latency: got %0d expected %0d", lat, LAT + 1);
    end
    n_cmp++;
    if (d !== e) begin
      n_err++;
      $display("FAIL single_sum: got %0d expected %0d", d, e);
    end
    n_cmp++;
    if (cnt !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL single_cnt: got %0d expected 1", cnt);
    end
    consume();
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle: got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    logic [15:0] d, e;
    logic [15:0] run;
    man_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    run = 16'd0;
    foreach (man_q[i]) begin
      ops_exp_q.push_back(run);
      run = run + man_q[i];
    end
    exp_q.push_back(run);
    drive_vector(16'd0, -1, 0, ok);
    n_cmp++;
    if (!ok || obs_ops.size() != 4) begin
      n_err++;
      $display("FAIL b2b_handshakes: got %0d expected 4", obs_ops.size());
      ops_exp_q.delete();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      e = ops_exp_q.pop_front();
      n_cmp++;
      if (obs_ops[i] !== e) begin
        n_err++;
        $display("FAIL b2b_ops%0d: got %0d expected %0d", i, obs_ops[i], e);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_cyc[i] - obs_cyc[i-1] !== LAT) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, obs_cyc[i] - obs_cyc[i-1], LAT);
        end
      end
    end
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== e) begin
      n_err++;
      $display("FAIL b2b_sum: got %0d expected %0d", d, e);
    end
    n_cmp++;
    if (cnt !== CNT_W'(4)) begin
      n_err++;
      $display("FAIL b2b_cnt: got %0d expected 4", cnt);
    end
    consume();
  endtask

  task automatic test_gaps();
    bit ok;
    int lat;
    logic [15:0] d, e;
    logic [15:0] run;
    man_q = '{16'd5, 16'd6, 16'd7};
    run = 16'd2;
    foreach (man_q[i]) begin
      ops_exp_q.push_back(run);
      run = run + man_q[i];
    end
    exp_q.push_back(run);
    drive_vector(16'd2, 2, 5, ok);
    n_cmp++;
    if (!ok || obs_ops.size() != 3) begin
      n_err++;
      $display("FAIL gap_handshakes: got %0d expected 3", obs_ops.size());
      ops_exp_q.delete();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      e = ops_exp_q.pop_front();
      n_cmp++;
      if (obs_ops[i] !== e) begin
        n_err++;
        $display("FAIL gap_ops%0d: got %0d expected %0d", i, obs_ops[i], e);
      end
    end
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== e) begin
      n_err++;
      $display("FAIL gap_sum: got %0d expected %0d", d, e);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [15:0] d, e;
    man_q = '{16'd4};
    exp_q.push_back(16'd5);
    drive_vector(16'd1, -1, 0, ok);
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || d !== e) begin
      n_err++;
      $display("FAIL bp_sum: got %0d expected %0d", d, e);
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        n_err++;
        $display("FAIL bp_hold%0d: got valid=%b data=%0d expected valid=1 data=%0d", i, out_valid, out_data, e);
      end
    end
    start = 1'b0;
    consume();
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL bp_idle: got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_clear();
    bit ok, seen;
    int k, lat;
    logic [15:0] d, e;
    start = 1'b1;
    bias  = 16'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_man   = 16'd2;
    in_last  = 1'b0;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL clear_idle: got %b expected 00", {busy, out_valid});
    end
    n_cmp++;
    if (cnt !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL clear_cnt: got %0d expected 1", cnt);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL clear_no_out: got %b expected 0", seen);
    end
    @(posedge clk); #1;
    man_q = '{16'd1};
    exp_q.push_back(16'd8);
    drive_vector(16'd7, -1, 0, ok);
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || d !== e) begin
      n_err++;
      $display("FAIL clear_restart_sum: got %0d expected %0d", d, e);
    end
    consume();
  endtask

  task automatic test_saturation();
    bit ok;
    int lat;
    logic [15:0] d, e;
    logic [15:0] run;
    man_q.delete();
    run = 16'd0;
    for (int i = 1; i <= 10; i++) begin
      man_q.push_back(16'(i));
      run = run + 16'(i);
    end
    exp_q.push_back(run);
    drive_vector(16'd0, -1, 0, ok);
    wait_out(lat, d, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || d !== e) begin
      n_err++;
      $display("FAIL sat_sum: got %0d expected %0d", d, e);
    end
    n_cmp++;
    if (cnt !== '1) begin
      n_err++;
      $display("FAIL sat_cnt: got %0d expected %0d", cnt, (1 << CNT_W) - 1);
    end
    consume();
  endtask

  task automatic test_async_reset();
    bit ok;
    man_q = '{16'd9};
    drive_vector(16'd0, -1, 0, ok);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b000 || cnt !== '0) begin
      n_err++;
      $display("FAIL arst_flags: got busy=%b valid=%b ready=%b cnt=%0d expected all 0", busy, out_valid, in_ready, cnt);
    end
    n_cmp++;
    if ({acc_ops, acc_man, out_data} !== 48'd0) begin
      n_err++;
      $display("FAIL arst_data: got %h expected 0", {acc_ops, acc_man, out_data});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL arst_idle%0d: got %b expected 0", i, busy);
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL arst_restart: got %b expected 1", busy);
    end
  endtask

  initial begin
    start = 1'b0;
    clear = 1'b0;
    bias = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_sgn = 1'b0;
    in_exp = '0;
    in_man = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_gaps();
    test_backpressure();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
